// File: rtl/crc_pkg.sv
// Shared types and helpers for the parametrised CRC engine.
// Holds the FSM state encoding, bit-reversal helpers and reference check values.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Standard check values for the ASCII string "123456789".
  localparam logic [7:0]  CHECK_CRC8_MAXIM   = 8'hA1;
  localparam logic [15:0] CHECK_CRC16_CCITT  = 16'h29B1;
  localparam logic [31:0] CHECK_CRC32        = 32'hCBF43926;

  function automatic logic [7:0] reverse8(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] reverse_w(input logic [31:0] v, input int w);
    logic [31:0] r;
    logic [4:0]  j;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      j = 5'(w - 1 - i);
      r[i] = (i < w) ? v[j] : 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational fold of BPC data bits into a CRC_W-bit register, MSB-first update.
// bits_in[0] is consumed first.
module crc_step #(
  parameter int          CRC_W = 8,
  parameter logic [31:0] POLY  = 32'h31,
  parameter int          BPC   = 1
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [BPC-1:0]   bits_in,
  output logic [CRC_W-1:0] crc_out
);

  localparam logic [CRC_W-1:0] POLY_T = POLY[CRC_W-1:0];

  logic [CRC_W-1:0] c;
  logic             fb;

  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = 0; i < BPC; i++) begin
      fb = c[CRC_W-1] ^ bits_in[i];
      c  = (c << 1) ^ (fb ? POLY_T : '0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc_engine.sv
// Serial CRC engine: one byte per 8/BPC+1 cycles over valid/ready, result on read request.
// The register re-initialises to INIT after every delivered result or clear.
module crc_engine
  import crc_pkg::*;
#(
  parameter int          CRC_W  = 8,
  parameter logic [31:0] POLY   = 32'h31,
  parameter logic [31:0] INIT   = 32'h0,
  parameter bit          REFIN  = 1'b1,
  parameter bit          REFOUT = 1'b1,
  parameter logic [31:0] XOROUT = 32'h0,
  parameter int          BPC    = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [7:0]       din_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  input  logic             crc_rd_i,
  output logic [CRC_W-1:0] crc_o,
  output logic             crc_valid_o,
  output logic             busy_o
);

  localparam logic [CRC_W-1:0] INIT_T = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_T  = XOROUT[CRC_W-1:0];
  localparam logic [3:0]       STEP   = 4'(BPC);
  localparam logic [3:0]       LAST   = 4'(8 - BPC);

  state_t           state;
  logic [CRC_W-1:0] crc_reg;
  logic [CRC_W-1:0] crc_next;
  logic [CRC_W-1:0] result;
  logic [3:0]       cnt;
  logic [7:0]       sreg;

  crc_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .BPC   (BPC)
  ) u_step (
    .crc_in  (crc_reg),
    .bits_in (sreg[BPC-1:0]),
    .crc_out (crc_next)
  );

  assign result = (REFOUT ? CRC_W'(reverse_w(32'(crc_reg), CRC_W)) : crc_reg) ^ XOR_T;

  assign din_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      crc_reg     <= INIT_T;
      crc_o       <= '0;
      crc_valid_o <= 1'b0;
      cnt         <= '0;
      sreg        <= '0;
    end else begin
      crc_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_i) begin
            crc_reg <= INIT_T;
          end else if (din_valid_i) begin
            // The shifter always eats bit 0 first; a non-reflected byte goes in MSB first.
            sreg  <= REFIN ? din_i : reverse8(din_i);
            cnt   <= '0;
            state <= BUSY;
          end else if (crc_rd_i) begin
            state <= DONE;
          end
        end
        BUSY: begin
          if (clear_i) begin
            crc_reg <= INIT_T;
            state   <= IDLE;
          end else begin
            crc_reg <= crc_next;
            sreg    <= sreg >> BPC;
            cnt     <= cnt + STEP;
            if (cnt == LAST) begin
              state <= IDLE;
            end
          end
        end
        DONE: begin
          // A clear arriving here does not suppress the result already requested.
          crc_o       <= result;
          crc_valid_o <= 1'b1;
          crc_reg     <= INIT_T;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_engine.sv
// Scoreboard bench for crc_engine: three configurations (CRC-8/MAXIM, CRC-16/CCITT-FALSE, CRC-32).
// Stimulus pushes expected results; a separate monitor pops them on crc_valid_o.
module tb_crc_engine;
  import crc_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  clr;
  logic [7:0]  din [3];
  logic [2:0]  dv;
  logic [2:0]  rdy;
  logic [2:0]  rd;
  logic [2:0]  vo;
  logic [2:0]  busy;
  logic [7:0]  c8;
  logic [15:0] c16;
  logic [31:0] c32;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          k;
    logic [31:0] v;
  } exp_t;
  exp_t q[$];

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  crc_engine u8 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr[0]), .din_i(din[0]), .din_valid_i(dv[0]),
    .din_ready_o(rdy[0]), .crc_rd_i(rd[0]), .crc_o(c8), .crc_valid_o(vo[0]), .busy_o(busy[0])
  );

  crc_engine #(
    .CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF), .REFIN(1'b0), .REFOUT(1'b0),
    .XOROUT(32'h0), .BPC(4)
  ) u16 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr[1]), .din_i(din[1]), .din_valid_i(dv[1]),
    .din_ready_o(rdy[1]), .crc_rd_i(rd[1]), .crc_o(c16), .crc_valid_o(vo[1]), .busy_o(busy[1])
  );

  crc_engine #(
    .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1),
    .XOROUT(32'hFFFFFFFF), .BPC(8)
  ) u32 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr[2]), .din_i(din[2]), .din_valid_i(dv[2]),
    .din_ready_o(rdy[2]), .crc_rd_i(rd[2]), .crc_o(c32), .crc_valid_o(vo[2]), .busy_o(busy[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_of(input int k);
    case (k)
      0:       return {24'h0, c8};
      1:       return {16'h0, c16};
      default: return c32;
    endcase
  endfunction

  task automatic send_byte(input int k, input logic [7:0] b);
    int n;
    din[k] = b;
    dv[k]  = 1'b1;
    n = 0;
    while (!rdy[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 dv[k] = 1'b0;
  endtask

  task automatic send_range(input int k, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(k, msg[i]);
  endtask

  // Returns the number of negedges waited until crc_valid_o is seen.
  task automatic do_read(input int k, input logic [31:0] exp, output int lat);
    int n;
    exp_t e;
    e.k = k;
    e.v = exp;
    q.push_back(e);
    rd[k] = 1'b1;
    n = 0;
    while (!vo[k] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("read_timeout", 32'(n), 32'd0);
    rd[k] = 1'b0;
    lat = n;
  endtask

  // Monitor: compares each result strobe against the scoreboard and checks strobe width.
  initial begin
    logic [2:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (vo[k]) begin
          chk("valid_single_cycle", 32'(prev[k]), 32'd0);
          if (q.size() == 0) begin
            chk("unexpected_result", crc_of(k), 32'hDEADBEEF);
          end else begin
            e = q.pop_front();
            chk("result_engine", 32'(k), 32'(e.k));
            chk("crc_value", crc_of(k), e.v);
          end
        end
        prev[k] = vo[k];
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int lat;
    rst = 1'b1;
    clr = '0;
    dv  = '0;
    rd  = '0;
    for (int k = 0; k < 3; k++) din[k] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_crc8",  {24'h0, c8}, 32'h0);
    chk("rst_crc16", {16'h0, c16}, 32'h0);
    chk("rst_crc32", c32, 32'h0);
    chk("rst_valid", 32'(vo), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_ready", 32'(rdy), 32'h7);

    // CRC-8/MAXIM, with ready-low duration on the first byte.
    send_byte(0, msg[0]);
    cnt = 0;
    @(negedge clk);
    while (!rdy[0] && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("maxim_ready_low_cycles", 32'(cnt), 32'd8);
    send_range(0, 1, 8);
    do_read(0, {24'h0, CHECK_CRC8_MAXIM}, lat);

    // CRC-16/CCITT-FALSE, BPC=4: two busy cycles per byte.
    send_byte(1, msg[0]);
    cnt = 0;
    @(negedge clk);
    while (busy[1] && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("ccitt_busy_cycles", 32'(cnt), 32'd2);
    send_range(1, 1, 8);
    do_read(1, {16'h0, CHECK_CRC16_CCITT}, lat);

    // CRC-32, BPC=8; an empty second read shows the re-init to INIT.
    send_range(2, 0, 8);
    do_read(2, CHECK_CRC32, lat);
    @(posedge clk);
    #1;
    do_read(2, 32'h00000000, lat);
    chk("read_latency_negedges", 32'(lat), 32'd3);

    // Clear during BUSY discards "123" and the partial fourth byte.
    send_range(0, 0, 3);
    @(negedge clk);
    clr[0] = 1'b1;
    @(posedge clk);
    #1 clr[0] = 1'b0;
    chk("clear_to_idle_busy", 32'(busy[0]), 32'd0);
    send_range(0, 0, 8);
    do_read(0, {24'h0, CHECK_CRC8_MAXIM}, lat);

    // Asynchronous reset between edges during the fifth byte.
    send_range(0, 0, 4);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_crc_o", {24'h0, c8}, 32'h0);
    chk("async_rst_busy",  32'(busy[0]), 32'd0);
    chk("async_rst_valid", 32'(vo[0]), 32'd0);
    chk("async_rst_ready", 32'(rdy[0]), 32'd1);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send_range(0, 0, 8);
    do_read(0, {24'h0, CHECK_CRC8_MAXIM}, lat);

    // Read request held together with the last byte: byte is taken first.
    send_range(0, 0, 7);
    rd[0] = 1'b1;
    send_byte(0, msg[8]);
    chk("held_read_busy_after_accept", 32'(busy[0]), 32'd1);
    do_read(0, {24'h0, CHECK_CRC8_MAXIM}, lat);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
